instruction_fetch_unit: RTL and testbench

Fetch stage sitting directly downstream of the program counter. Takes `pc_current`, issues one word request to instruction memory over a valid/ready handshake, and waits for a response of variable latency. Holds the returned instruction and its PC for decode. Drives `fetch_stall` back to the PC, which holds `pc_current` until decode accepts the instruction. Single outstanding request; redirects flush in-flight work.

---
 rtl/instruction_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//
// Fetch stage directly downstream of the program counter. It issues one word
// request per instruction to instruction memory over a valid/ready handshake
// and waits for a variable-latency response. It holds the returned word and
// its PC for decode. Only one request is outstanding at a time. A redirect
// (flush) discards both the held instruction and any in-flight response.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   When defined, a misaligned PC issues no memory request. Instead, NOP_INSTR
//   is presented with fetch_fault set. When undefined, fetch_fault is always 0
//   and the low address bits are simply cleared.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   pc_current        PC to fetch, from the program counter
//   fetch_stall       hold request to the PC (low on decode accept or flush)
//   flush             redirect: drop current and in-flight fetch
//   imem_req_*        request channel to instruction memory (valid/ready/addr)
//   imem_rsp_*        response channel from instruction memory (valid/data)
//   instr_valid/ready handshake with decode
//   instr_out         fetched instruction word
//   instr_pc          PC of instr_out
//   fetch_fault       misaligned-fetch flag, valid while instr_valid is high
module instruction_fetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_current,
  output logic        fetch_stall,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        fault_q, fault_d;
  logic        misaligned;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = |pc_current[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      drop_q      <= 1'b0;
      req_pc_q    <= '0;
      instr_out_q <= '0;
      instr_pc_q  <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      req_pc_q    <= req_pc_d;
      instr_out_q <= instr_out_d;
      instr_pc_q  <= instr_pc_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    drop_d         = drop_q;
    req_pc_d       = req_pc_q;
    instr_out_d    = instr_out_q;
    instr_pc_d     = instr_pc_q;
    fault_d        = fault_q;
    imem_req_valid = 1'b0;

    case (state_q)
      StIdle: state_d = StReq;

      StReq: begin
        if (misaligned) begin
          // Trap instead of fetching; a flush retargets the PC, so retry.
          if (!flush) begin
            state_d     = StHold;
            instr_out_d = NOP_INSTR;
            instr_pc_d  = pc_current;
            fault_d     = 1'b1;
          end
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) begin
            req_pc_d = pc_current;
            state_d  = StWait;
            // A request accepted under flush is already stale.
            drop_d   = flush;
          end
        end
      end

      StWait: begin
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (drop_q || flush) begin
            state_d = StReq;
          end else begin
            instr_out_d = imem_rsp_data;
            instr_pc_d  = req_pc_q;
            state_d     = StHold;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end

      StHold: begin
        if (flush || instr_ready) begin
          state_d = StReq;
          fault_d = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign imem_req_addr = {pc_current[31:2], 2'b00};
  // Flush masks valid so decode never accepts an instruction being discarded.
  assign instr_valid   = (state_q == StHold) && !flush;
  assign fetch_stall   = !(((state_q == StHold) && instr_ready) || flush);
  assign instr_out     = instr_out_q;
  assign instr_pc      = instr_pc_q;
  assign fetch_fault   = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit. Inputs change 1 ns
// after each rising edge, and outputs are checked 2 ns later.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_current;
  logic        fetch_stall;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.NOP_INSTR(32'h00000013)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_current     (pc_current),
    .fetch_stall    (fetch_stall),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_instr_valid"}, instr_valid, 1'b0);
    chk({tag, "_instr_out"}, instr_out, 32'h0);
    chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    chk1({tag, "_fault"}, fetch_fault, 1'b0);
    chk1({tag, "_req_valid"}, imem_req_valid, 1'b0);
    chk1({tag, "_stall"}, fetch_stall, 1'b1);
  endtask

  // Watchdog: the sequence below is a few hundred ns long.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, errors so far=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc_current = 32'h0; flush = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; instr_ready = 1'b0;
    #2;
    chk_reset_vals("rst");
    nxt(); nxt();
    reset = 1'b0;
    #2;
    chk1("idle_req_valid", imem_req_valid, 1'b0);

    // --- Basic fetch: ready at once, 1-cycle response ---
    nxt();                                  // IDLE -> REQ
    imem_req_ready = 1'b1;
    #2;
    chk1("t1_req_valid", imem_req_valid, 1'b1);
    chk("t1_addr", imem_req_addr, 32'h0);
    chk1("t1_stall_req", fetch_stall, 1'b1);
    nxt();                                  // accepted -> WAIT
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00500093;
    #2;
    chk1("t1_wait_req_valid", imem_req_valid, 1'b0);
    chk1("t1_wait_ivalid", instr_valid, 1'b0);
    chk1("t1_wait_stall", fetch_stall, 1'b1);
    nxt();                                  // captured -> HOLD
    imem_rsp_valid = 1'b0; instr_ready = 1'b1;
    #2;
    chk1("t1_ivalid", instr_valid, 1'b1);
    chk("t1_instr", instr_out, 32'h00500093);
    chk("t1_pc", instr_pc, 32'h0);
    chk1("t1_stall_accept", fetch_stall, 1'b0);
    nxt();                                  // -> REQ, PC advanced
    instr_ready = 1'b0; pc_current = 32'h4;
    #2;
    chk1("t1_after_stall", fetch_stall, 1'b1);
    chk1("t1_after_ivalid", instr_valid, 1'b0);

    // --- Memory not ready for 4 cycles, then 3-cycle response latency ---
    for (int i = 0; i < 4; i++) begin
      chk1("t2_req_valid", imem_req_valid, 1'b1);
      chk("t2_addr", imem_req_addr, 32'h4);
      chk1("t2_stall", fetch_stall, 1'b1);
      nxt();
      #2;
    end
    imem_req_ready = 1'b1;
    #1;
    chk1("t2_req_valid_acc", imem_req_valid, 1'b1);
    nxt();                                  // -> WAIT
    imem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk1("t2_wait_ivalid", instr_valid, 1'b0);
      chk1("t2_wait_stall", fetch_stall, 1'b1);
      nxt();
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00a00113;
    nxt();                                  // -> HOLD
    imem_rsp_valid = 1'b0;
    #2;
    chk1("t2_ivalid", instr_valid, 1'b1);
    chk("t2_instr", instr_out, 32'h00a00113);
    chk("t2_pc", instr_pc, 32'h4);

    // --- Decode back-pressure for 5 cycles; stray response ignored ---
    for (int i = 0; i < 5; i++) begin
      imem_rsp_valid = (i == 2); imem_rsp_data = 32'hffffffff;
      #1;
      chk1("t3_ivalid", instr_valid, 1'b1);
      chk("t3_instr", instr_out, 32'h00a00113);
      chk("t3_pc", instr_pc, 32'h4);
      chk1("t3_stall", fetch_stall, 1'b1);
      chk1("t3_no_req", imem_req_valid, 1'b0);
      nxt();
    end
    imem_rsp_valid = 1'b0; instr_ready = 1'b1;
    #2;
    chk1("t3_stall_accept", fetch_stall, 1'b0);
    nxt();                                  // -> REQ
    instr_ready = 1'b0; pc_current = 32'h8;

    // --- Flush during WAIT, stale response dropped, refetch at 0x100 ---
    imem_req_ready = 1'b1;
    nxt();                                  // -> WAIT
    imem_req_ready = 1'b0; flush = 1'b1;
    #2;
    chk1("t4_flush_stall", fetch_stall, 1'b0);
    nxt();                                  // drop set, still WAIT
    flush = 1'b0; pc_current = 32'h100;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hdeadbeef;
    #2;
    chk1("t4_wait_ivalid", instr_valid, 1'b0);
    chk1("t4_wait_req_valid", imem_req_valid, 1'b0);
    nxt();                                  // stale dropped -> REQ
    imem_rsp_valid = 1'b0;
    #2;
    chk1("t4_req_valid", imem_req_valid, 1'b1);
    chk("t4_addr", imem_req_addr, 32'h100);
    chk1("t4_no_stale_valid", instr_valid, 1'b0);
    chk("t4_no_stale_instr", instr_out, 32'h00a00113);
    imem_req_ready = 1'b1;
    nxt();                                  // -> WAIT
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00000013;
    nxt();                                  // -> HOLD
    imem_rsp_valid = 1'b0;
    #2;
    chk1("t4_ivalid", instr_valid, 1'b1);
    chk("t4_instr", instr_out, 32'h00000013);
    chk("t4_pc", instr_pc, 32'h100);

    // --- Flush in HOLD beats simultaneous instr_ready ---
    flush = 1'b1; instr_ready = 1'b1;
    #1;
    chk1("t4h_ivalid_masked", instr_valid, 1'b0);
    chk1("t4h_stall", fetch_stall, 1'b0);
    nxt();                                  // -> REQ
    flush = 1'b0; instr_ready = 1'b0; pc_current = 32'h6;
    #2;

    // --- Misaligned PC 0x6 ---
`ifdef FETCH_MISALIGN_TRAP_EN
    chk1("t5_no_req", imem_req_valid, 1'b0);
    nxt();                                  // -> HOLD with trap
    #2;
    chk1("t5_ivalid", instr_valid, 1'b1);
    chk1("t5_fault", fetch_fault, 1'b1);
    chk("t5_instr", instr_out, 32'h00000013);
    chk("t5_pc", instr_pc, 32'h6);
    chk1("t5_no_req_hold", imem_req_valid, 1'b0);
    instr_ready = 1'b1;
    nxt();                                  // -> REQ
    instr_ready = 1'b0; pc_current = 32'h200;
    #2;
    chk1("t5_fault_clear", fetch_fault, 1'b0);
`else
    chk1("t5_req_valid", imem_req_valid, 1'b1);
    chk("t5_addr", imem_req_addr, 32'h4);
    chk1("t5_fault_req", fetch_fault, 1'b0);
    imem_req_ready = 1'b1;
    nxt();                                  // -> WAIT
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00100073;
    nxt();                                  // -> HOLD
    imem_rsp_valid = 1'b0;
    #2;
    chk1("t5_ivalid", instr_valid, 1'b1);
    chk("t5_instr", instr_out, 32'h00100073);
    chk("t5_pc", instr_pc, 32'h6);
    chk1("t5_fault", fetch_fault, 1'b0);
    instr_ready = 1'b1;
    nxt();                                  // -> REQ
    instr_ready = 1'b0; pc_current = 32'h200;
    #2;
`endif

    // --- Reset during WAIT with drop pending ---
    imem_req_ready = 1'b1;
    nxt();                                  // -> WAIT
    imem_req_ready = 1'b0; flush = 1'b1;
    nxt();                                  // drop set
    flush = 1'b0; reset = 1'b1;
    #2;
    chk_reset_vals("t6");
    nxt();
    reset = 1'b0;
    #2;
    chk1("t6_idle_req_valid", imem_req_valid, 1'b0);
    nxt();                                  // -> REQ
    #2;
    chk1("t6_req_valid", imem_req_valid, 1'b1);
    chk("t6_addr", imem_req_addr, 32'h200);
    imem_req_ready = 1'b1;
    nxt();                                  // -> WAIT
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h12345678;
    nxt();                                  // drop was cleared by reset -> HOLD
    imem_rsp_valid = 1'b0;
    #2;
    chk1("t6_ivalid", instr_valid, 1'b1);
    chk("t6_instr", instr_out, 32'h12345678);
    chk("t6_pc", instr_pc, 32'h200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
